// File: rtl/breed_stage_if.sv
// Bundle of the breed_stage data/handshake signals. The master side requests a
// generation and supplies parents and seed; the slave side returns the bred
// population and the completion flag.
interface breed_stage_if #(
  parameter int GENE_W = 15,
  parameter int N_SEL  = 100,
  parameter int N_POP  = 500
);
  logic                    start;
  logic [N_SEL*GENE_W-1:0] sel_pop;
  logic [31:0]             prg_seed;
  logic [N_POP*GENE_W-1:0] new_pop;
  logic                    done;

  modport master (
    output start,
    output sel_pop,
    output prg_seed,
    input  new_pop,
    input  done
  );

  modport slave (
    input  start,
    input  sel_pop,
    input  prg_seed,
    output new_pop,
    output done
  );
endinterface

// File: rtl/breed_stage.sv
// GA breeding stage: copies every parent into the new population unchanged,
// then fills the remaining slots with single-point crossover children of
// randomly paired parents, each optionally hit by a one-bit mutation.
// Randomness comes from a 32-bit Galois LFSR loaded once per generation, so a
// given parent set, seed and parameter set always yields the same population.
module breed_stage #(
  parameter int GENE_W   = 15,
  parameter int N_SEL    = 100,
  parameter int N_POP    = 500,
  parameter int MUT_RATE = 8
) (
  input  logic         clk,
  input  logic         rst,
  breed_stage_if.slave bus
);

  localparam int          IDX_W     = (N_SEL > 1) ? $clog2(N_SEL) : 1;
  localparam int          POS_W     = (GENE_W > 1) ? $clog2(GENE_W) : 1;
  localparam int          POP_IW    = $clog2(N_POP);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PICK,
    S_MAKE,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [POP_IW-1:0]   idx_q, idx_d;
  logic [GENE_W-1:0]   par_a_q, par_a_d;
  logic [GENE_W-1:0]   par_b_q, par_b_d;
  logic                done_q, done_d;
  logic [GENE_W-1:0]   pop_q [N_POP];
  logic [GENE_W-1:0]   pop_d [N_POP];

  logic [31:0]         lfsr_adv;
  logic [31:0]         prod_a, prod_b, prod_c, prod_m;
  logic [IDX_W-1:0]    a_idx, b_idx;
  logic [POS_W-1:0]    cut, mut_pos;
  logic                mut_hit;
  logic [GENE_W-1:0]   child;

  // One right shift of the Galois LFSR; bit 0 falling out folds the taps back in.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // Random fields taken from the LFSR state this cycle advances to. The same
  // advanced state serves as s1 in PICK and as s2 in MAKE.
  always_comb begin
    lfsr_adv = lfsr_step(lfsr_q);
    // Multiply-high scaling keeps every index strictly below its range bound.
    prod_a   = 32'(lfsr_adv[15:0])  * 32'(N_SEL);
    prod_b   = 32'(lfsr_adv[31:16]) * 32'(N_SEL);
    prod_c   = 32'(lfsr_adv[7:0])   * 32'(GENE_W - 1);
    prod_m   = 32'(lfsr_adv[23:16]) * 32'(GENE_W);
    a_idx    = IDX_W'(prod_a >> 16);
    b_idx    = IDX_W'(prod_b >> 16);
    cut      = POS_W'(1) + POS_W'(prod_c >> 8);
    mut_pos  = POS_W'(prod_m >> 8);
    // Nine-bit compare so MUT_RATE = 256 mutates every child.
    mut_hit  = ({1'b0, lfsr_adv[15:8]} < 9'(MUT_RATE));
  end

  // Crossover: low bits below the cut from parent A, the rest from parent B,
  // then the optional single-bit flip.
  always_comb begin
    // NOTE: every combinational output gets a full default before any
    // conditional update, so no path leaves it unassigned and no latch forms.
    child = par_b_q;
    for (int j = 0; j < GENE_W; j++) begin
      if (j < int'(cut)) child[j] = par_a_q[j];
    end
    child[mut_pos] = child[mut_pos] ^ mut_hit;
  end

  // Next-state, LFSR, parent latch and population update.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    par_a_d = par_a_q;
    par_b_d = par_b_q;
    done_d  = 1'b0;
    pop_d   = pop_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_LOAD;
      end

      S_LOAD: begin
        // A zero seed would lock the LFSR at zero forever.
        lfsr_d = (bus.prg_seed == 32'h0) ? 32'h0000_0001 : bus.prg_seed;
        // The elite slots double as the latched parent copy: they are never
        // overwritten while children are bred, so PICK reads parents there.
        for (int k = 0; k < N_SEL; k++) begin
          pop_d[k] = bus.sel_pop[k*GENE_W +: GENE_W];
        end
        idx_d   = POP_IW'(N_SEL);
        state_d = S_PICK;
      end

      S_PICK: begin
        lfsr_d  = lfsr_adv;
        par_a_d = pop_q[POP_IW'(a_idx)];
        par_b_d = pop_q[POP_IW'(b_idx)];
        state_d = S_MAKE;
      end

      S_MAKE: begin
        lfsr_d       = lfsr_adv;
        pop_d[idx_q] = child;
        if (idx_q == POP_IW'(N_POP - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + POP_IW'(1);
          state_d = S_PICK;
        end
      end

      S_DONE: begin
        // done rises one cycle after DONE is entered and then holds. A start
        // seen while done is already high drops it at the accepting edge; a
        // start seen in the very first DONE cycle still lets the one-cycle
        // pulse through, which is what a held-high start produces.
        done_d = ~(done_q & bus.start);
        if (bus.start) state_d = S_LOAD;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    if (rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      idx_q   <= '0;
      par_a_q <= '0;
      par_b_q <= '0;
      done_q  <= 1'b0;
      // NOTE: the population array is reset explicitly because the output
      // must read as all zeros right after reset, not merely be ignored.
      for (int k = 0; k < N_POP; k++) begin
        pop_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      par_a_q <= par_a_d;
      par_b_q <= par_b_d;
      done_q  <= done_d;
      pop_q   <= pop_d;
    end
  end

  // Pack the population array onto the flat output bus.
  for (genvar k = 0; k < N_POP; k++) begin : g_pack
    assign bus.new_pop[k*GENE_W +: GENE_W] = pop_q[k];
  end

  assign bus.done = done_q;

endmodule
